// File: rtl/addr_gen.sv
// Address generator: destination MAR, column/row scan counters and a registered source address.
// Optional `ADDR_GEN_BOUNDS_EN: saturate MAR at MAR_LIMIT and raise a sticky oob flag.
module addr_gen #(
    parameter int unsigned        ADDR_W    = 16,
    parameter int unsigned        LOG2_W    = 8,
    parameter int unsigned        ROW_W     = 8,
    parameter int unsigned        IMG_H     = 256,
    parameter logic [ADDR_W-1:0]  SRC_BASE  = '0,
    parameter logic [ADDR_W-1:0]  DST_BASE  = 16'h8000,
    parameter logic [ADDR_W-1:0]  MAR_LIMIT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              mar_inc,
    input  logic              col_inc,
    input  logic              row_inc,
    input  logic              col_zero,
    input  logic              mar_load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] mar,
    output logic [LOG2_W-1:0] col,
    output logic [ROW_W-1:0]  row,
    output logic [ADDR_W-1:0] src_addr,
    output logic              frame_done,
    output logic              oob
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [LOG2_W-1:0] col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] src_addr_q, src_addr_d;
    logic              frame_done_q, frame_done_d;
`ifdef ADDR_GEN_BOUNDS_EN
    logic              oob_q, oob_d;
`endif

    always_comb begin
        mar_d        = mar_q;
        col_d        = col_q;
        row_d        = row_q;
        src_addr_d   = src_addr_q;
        frame_done_d = 1'b0;
`ifdef ADDR_GEN_BOUNDS_EN
        oob_d        = oob_q;
`endif
        if (enable) begin
            if (mar_load) begin
                mar_d = load_val;
`ifdef ADDR_GEN_BOUNDS_EN
                oob_d = 1'b0;
`endif
            end else if (mar_inc) begin
`ifdef ADDR_GEN_BOUNDS_EN
                if (mar_q == MAR_LIMIT) begin
                    oob_d = 1'b1;
                end else begin
                    mar_d = mar_q + ADDR_W'(1);
                end
`else
                // Plain modulo step; the limit term folds to the natural wrap.
                mar_d = (mar_q == MAR_LIMIT && MAR_LIMIT == '1) ? '0 : mar_q + ADDR_W'(1);
`endif
            end

            if (col_zero) begin
                col_d = '0;
            end else if (col_inc) begin
                col_d = col_q + LOG2_W'(1);
            end

            if (row_inc) begin
                if (row_q == ROW_LAST) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + ROW_W'(1);
                end
            end

            // Uses pre-update counters, giving the one-cycle lag behind row/col.
            src_addr_d = SRC_BASE + ADDR_W'({row_q, col_q});
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mar_q        <= DST_BASE;
            col_q        <= '0;
            row_q        <= '0;
            src_addr_q   <= SRC_BASE;
            frame_done_q <= 1'b0;
        end else begin
            mar_q        <= mar_d;
            col_q        <= col_d;
            row_q        <= row_d;
            src_addr_q   <= src_addr_d;
            frame_done_q <= frame_done_d;
        end
    end

`ifdef ADDR_GEN_BOUNDS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            oob_q <= 1'b0;
        end else begin
            oob_q <= oob_d;
        end
    end
    assign oob = oob_q;
`else
    assign oob = 1'b0;
`endif

    assign mar        = mar_q;
    assign col        = col_q;
    assign row        = row_q;
    assign src_addr   = src_addr_q;
    assign frame_done = frame_done_q & enable;

endmodule

// File: tb/tb_addr_gen.sv
// Randomized self-checking bench for addr_gen against an arithmetic reference model.
// Honours `ADDR_GEN_BOUNDS_EN the same way as the design build.
module tb_addr_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        mar_inc = 1'b0, col_inc = 1'b0, row_inc = 1'b0, col_zero = 1'b0, mar_load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] mar, src_addr;
    logic [7:0]  col, row;
    logic        frame_done, oob;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state as plain integers
    int m_mar, m_col, m_row, m_src, m_fd, m_oob;

    addr_gen #(
        .ADDR_W(16), .LOG2_W(8), .ROW_W(8), .IMG_H(256),
        .SRC_BASE(16'h0000), .DST_BASE(16'h8000), .MAR_LIMIT(16'hFFFF)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mar_inc(mar_inc), .col_inc(col_inc), .row_inc(row_inc), .col_zero(col_zero),
        .mar_load(mar_load), .load_val(load_val),
        .mar(mar), .col(col), .row(row), .src_addr(src_addr),
        .frame_done(frame_done), .oob(oob)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mar = 32'h8000; m_col = 0; m_row = 0; m_src = 0; m_fd = 0; m_oob = 0;
    endtask

    task automatic model_step();
        int next_src;
        if (!reset) begin
            model_reset();
        end else if (enable) begin
            next_src = (m_row * 256 + m_col) % 65536;
            if (mar_load) begin
                m_mar = load_val; m_oob = 0;
            end else if (mar_inc) begin
`ifdef ADDR_GEN_BOUNDS_EN
                if (m_mar == 65535) m_oob = 1;
                else m_mar = m_mar + 1;
`else
                m_mar = (m_mar + 1) % 65536;
`endif
            end
            if (col_zero) m_col = 0;
            else if (col_inc) m_col = (m_col + 1) % 256;
            m_fd = 0;
            if (row_inc) begin
                if (m_row == 255) begin m_row = 0; m_fd = 1; end
                else m_row = m_row + 1;
            end
            m_src = next_src;
        end else begin
            m_fd = 0;
        end
    endtask

    // Drive one cycle of inputs, compare outputs mid-cycle, then advance the model past the edge.
    task automatic apply(input logic rst, input logic en, input logic mi, input logic ci,
                         input logic ri, input logic cz, input logic ml, input logic [15:0] lv);
        @(negedge clk);
        reset = rst; enable = en; mar_inc = mi; col_inc = ci; row_inc = ri;
        col_zero = cz; mar_load = ml; load_val = lv;
        #1;
        check("mar", 32'(mar), 32'(m_mar));
        check("col", 32'(col), 32'(m_col));
        check("row", 32'(row), 32'(m_row));
        check("src_addr", 32'(src_addr), 32'(m_src));
        check("frame_done", 32'(frame_done), 32'(m_fd & int'(en)));
        check("oob", 32'(oob), 32'(m_oob));
        @(posedge clk);
        #2;
        model_step();
    endtask

    task automatic idle();
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        model_reset();

        // Reset values
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
        check("rst_mar", 32'(mar), 32'h8000);
        check("rst_col", 32'(col), 32'h0);
        check("rst_row", 32'(row), 32'h0);
        check("rst_src", 32'(src_addr), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);

        // col=2,row=1 then col_inc; src follows one cycle later
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        repeat (2) apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("col_3", 32'(col), 32'h3);
        idle();
        check("src_0103", 32'(src_addr), 32'h0103);

        // Column wrap without row change
        repeat (252) apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("col_255", 32'(col), 32'd255);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        check("colwrap_col", 32'(col), 32'h0);
        check("colwrap_row", 32'(row), 32'h1);

        // col=5,row=3 then row_inc + col_zero + col_inc
        repeat (5) apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        repeat (2) apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        check("combo_row", 32'(row), 32'h4);
        check("combo_col", 32'(col), 32'h0);

        // Row wrap and one-cycle frame_done
        repeat (251) apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("row_255", 32'(row), 32'd255);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("rowwrap_row", 32'(row), 32'h0);
        check("rowwrap_fd", 32'(frame_done), 32'h1);
        idle();
        check("fd_one_cycle", 32'(frame_done), 32'h0);

        // Load beats increment; disabled increment is ignored
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
        check("load_mar", 32'(mar), 32'h1234);
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
        check("disabled_mar", 32'(mar), 32'h1234);

        // MAR at its limit
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
`ifdef ADDR_GEN_BOUNDS_EN
        check("limit_mar", 32'(mar), 32'hFFFF);
        check("limit_oob", 32'(oob), 32'h1);
        idle();
        check("oob_sticky", 32'(oob), 32'h1);
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0010);
        check("oob_cleared", 32'(oob), 32'h0);
`else
        check("wrap_mar", 32'(mar), 32'h0);
        check("wrap_oob", 32'(oob), 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] lv;
            lv = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
            apply(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 7) != 0),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 15) == 0),
                  lv);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
